// File: rtl/hf_line_collector.sv
// Collects Huffman big_values pairs and count1 quads into NUM_LINES indexed, zero-filled samples.
// Optional build macro: HF_COLLECTOR_CHECK_EN enables the sticky protocol-error flag err.
module hf_line_collector #(
  parameter int NUM_LINES  = 576,
  parameter int FIFO_DEPTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [8:0]         big_values,
  input  logic               pair_valid,
  input  logic signed [15:0] x_val,
  input  logic signed [15:0] y_val,
  input  logic               quad_valid,
  input  logic signed [1:0]  quad_v,
  input  logic signed [1:0]  quad_w,
  input  logic signed [1:0]  quad_x,
  input  logic signed [1:0]  quad_y,
  input  logic               count1_done,
  output logic               in_ready,
  output logic               line_valid,
  input  logic               line_ready,
  output logic [9:0]         line_idx,
  output logic signed [15:0] line_val,
  output logic               granule_done,
  output logic               err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [9:0]    LINES = 10'(NUM_LINES);
  localparam logic [8:0]    HALF  = 9'(NUM_LINES / 2);
  localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_BIG    = 3'd1,
    S_COUNT1 = 3'd2,
    S_ZFILL  = 3'd3,
    S_DRAIN  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [8:0]         bv_q, bv_d, pair_cnt_q, pair_cnt_d;
  logic [9:0]         line_cnt_q, line_cnt_d, out_idx_q, out_idx_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic signed [15:0] mem_q [FIFO_DEPTH];
  logic signed [15:0] mem_d [FIFO_DEPTH];
  logic               granule_done_q, granule_done_d, err_q, err_d;

  logic               in_ready_s, pop_s, final_pop_s, quad_take_s;
  logic [2:0]         push_n_s;
  logic [9:0]         room_s;
  logic [8:0]         bv_clamp_s;
  logic signed [15:0] push_dat_s [4];

  assign room_s      = LINES - line_cnt_q;
  // Four free slots guarantee a whole quad can land in one cycle.
  assign in_ready_s  = ((state_q == S_BIG) || (state_q == S_COUNT1)) &&
                       ((DEPTH - cnt_q) >= CW'(4));
  assign pop_s       = (cnt_q != {CW{1'b0}}) && line_ready;
  assign final_pop_s = pop_s && (out_idx_q == (LINES - 10'd1));
  assign quad_take_s = (state_q == S_COUNT1) && quad_valid && in_ready_s;
  assign bv_clamp_s  = (big_values > HALF) ? HALF : big_values;

  // Next-state, FIFO push/pop and error-flag computation.
  always_comb begin
    state_d        = state_q;
    bv_d           = bv_q;
    pair_cnt_d     = pair_cnt_q;
    line_cnt_d     = line_cnt_q;
    granule_done_d = 1'b0;
    push_n_s       = 3'd0;
    for (int i = 0; i < 4; i++) push_dat_s[i] = 16'sd0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          bv_d       = bv_clamp_s;
          line_cnt_d = 10'd0;
          pair_cnt_d = 9'd0;
          state_d    = (bv_clamp_s != 9'd0) ? S_BIG : S_COUNT1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BIG: begin
        if (pair_valid && in_ready_s) begin
          push_n_s      = 3'd2;
          push_dat_s[0] = x_val;
          push_dat_s[1] = y_val;
          line_cnt_d    = line_cnt_q + 10'd2;
          pair_cnt_d    = pair_cnt_q + 9'd1;
          state_d       = (pair_cnt_d == bv_q) ? S_COUNT1 : S_BIG;
        end else begin
          state_d = S_BIG;
        end
      end
      S_COUNT1: begin
        if (quad_take_s) begin
          push_n_s      = (room_s >= 10'd4) ? 3'd4 : room_s[2:0];
          push_dat_s[0] = {{14{quad_v[1]}}, quad_v};
          push_dat_s[1] = {{14{quad_w[1]}}, quad_w};
          push_dat_s[2] = {{14{quad_x[1]}}, quad_x};
          push_dat_s[3] = {{14{quad_y[1]}}, quad_y};
          line_cnt_d    = line_cnt_q + {7'd0, push_n_s};
        end else begin
          push_n_s = 3'd0;
        end
        state_d = (count1_done || (line_cnt_d == LINES)) ? S_ZFILL : S_COUNT1;
      end
      S_ZFILL: begin
        if (line_cnt_q == LINES) begin
          state_d = S_DRAIN;
        end else if (cnt_q < DEPTH) begin
          push_n_s   = 3'd1;
          line_cnt_d = line_cnt_q + 10'd1;
          state_d    = (line_cnt_d == LINES) ? S_DRAIN : S_ZFILL;
        end else begin
          state_d = S_ZFILL;
        end
      end
      S_DRAIN: state_d = S_DRAIN;
      default: state_d = S_IDLE;
    endcase

    if (final_pop_s) begin
      state_d        = S_IDLE;
      granule_done_d = 1'b1;
      out_idx_d      = 10'd0;
    end else if (pop_s) begin
      out_idx_d = out_idx_q + 10'd1;
    end else if ((state_q == S_IDLE) && start) begin
      out_idx_d = 10'd0;
    end else begin
      out_idx_d = out_idx_q;
    end

    wr_ptr_d = wr_ptr_q + AW'(push_n_s);
    rd_ptr_d = rd_ptr_q + AW'(pop_s);
    cnt_d    = cnt_q + CW'(push_n_s) - CW'(pop_s);
    mem_d    = mem_q;
    for (int i = 0; i < 4; i++) begin
      mem_d[wr_ptr_q + AW'(i)] = (3'(i) < push_n_s) ? push_dat_s[i]
                                                    : mem_d[wr_ptr_q + AW'(i)];
    end

`ifdef HF_COLLECTOR_CHECK_EN
    err_d = err_q
          | ((state_q == S_IDLE) && start && (big_values > HALF))
          | (pair_valid && ((state_q == S_COUNT1) || (state_q == S_ZFILL)))
          | (quad_valid && ((state_q == S_BIG) || (state_q == S_ZFILL)))
          | ((pair_valid || quad_valid) && !in_ready_s)
          | (quad_take_s && (room_s < 10'd4));
`else
    err_d = 1'b0;
`endif
  end

  // State, counters and FIFO storage; rst empties everything at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      bv_q           <= 9'd0;
      pair_cnt_q     <= 9'd0;
      line_cnt_q     <= 10'd0;
      out_idx_q      <= 10'd0;
      wr_ptr_q       <= {AW{1'b0}};
      rd_ptr_q       <= {AW{1'b0}};
      cnt_q          <= {CW{1'b0}};
      granule_done_q <= 1'b0;
      err_q          <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 16'sd0;
    end else begin
      state_q        <= state_d;
      bv_q           <= bv_d;
      pair_cnt_q     <= pair_cnt_d;
      line_cnt_q     <= line_cnt_d;
      out_idx_q      <= out_idx_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      cnt_q          <= cnt_d;
      granule_done_q <= granule_done_d;
      err_q          <= err_d;
      mem_q          <= mem_d;
    end
  end

  assign in_ready     = in_ready_s;
  assign line_valid   = (cnt_q != {CW{1'b0}});
  assign line_idx     = out_idx_q;
  assign line_val     = mem_q[rd_ptr_q];
  assign granule_done = granule_done_q;
  assign err          = err_q;
endmodule

// File: tb/tb_hf_line_collector.sv
// Self-checking bench for hf_line_collector: table of granule scenarios with random data
// checked against a line-array model, plus hand sequences for fixed data and mid-granule reset.
module tb_hf_line_collector;
  localparam int NL = 576;
`ifdef HF_COLLECTOR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst, start, pair_valid, quad_valid, count1_done, line_ready;
  logic [8:0]         big_values;
  logic signed [15:0] x_val, y_val;
  logic signed [1:0]  quad_v, quad_w, quad_x, quad_y;
  logic               in_ready, line_valid, granule_done, err;
  logic [9:0]         line_idx;
  logic signed [15:0] line_val;

  hf_line_collector dut (
    .clk(clk), .rst(rst), .start(start), .big_values(big_values),
    .pair_valid(pair_valid), .x_val(x_val), .y_val(y_val),
    .quad_valid(quad_valid), .quad_v(quad_v), .quad_w(quad_w),
    .quad_x(quad_x), .quad_y(quad_y), .count1_done(count1_done),
    .in_ready(in_ready), .line_valid(line_valid), .line_ready(line_ready),
    .line_idx(line_idx), .line_val(line_val), .granule_done(granule_done),
    .err(err)
  );

  typedef struct {
    int bv;           // big_values applied at start
    int nq;           // count1 quads offered
    int ready_pct;    // consumer acceptance probability
    int stall;        // cycles of line_ready=0 at granule start
    int stall_pairs;  // pairs the FIFO absorbs before in_ready drops
    bit exp_err;      // err expected in the checking build
  } vec_t;

  int checks = 0;
  int failures = 0;
  logic signed [15:0] px[$], py[$], exp_lines[$];
  logic signed [1:0]  qv[$], qw[$], qx[$], qy[$];
  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  function automatic logic signed [1:0] rand_tri();
    return 2'(int'($urandom_range(2, 0)) - 1);
  endfunction

  task automatic gen_random(input int bvc, input int nq);
    px.delete(); py.delete(); qv.delete(); qw.delete(); qx.delete(); qy.delete();
    for (int i = 0; i < bvc; i++) begin
      px.push_back(16'($urandom));
      py.push_back(16'($urandom));
    end
    for (int i = 0; i < nq; i++) begin
      qv.push_back(rand_tri()); qw.push_back(rand_tri());
      qx.push_back(rand_tri()); qy.push_back(rand_tri());
    end
  endtask

  // Reference: pairs then quads fill lines in order, anything past NL is dropped, rest is zero.
  task automatic build_model(input int bvc, input int nq);
    logic signed [15:0] t;
    exp_lines.delete();
    for (int i = 0; i < bvc; i++) begin
      exp_lines.push_back(px[i]);
      exp_lines.push_back(py[i]);
    end
    for (int i = 0; i < nq; i++) begin
      for (int k = 0; k < 4; k++) begin
        case (k)
          0: t = qv[i];
          1: t = qw[i];
          2: t = qx[i];
          default: t = qy[i];
        endcase
        if (exp_lines.size() < NL) exp_lines.push_back(t);
      end
    end
    while (exp_lines.size() < NL) exp_lines.push_back(16'sd0);
  endtask

  task automatic idle_inputs();
    start = 1'b0; big_values = 9'd0; pair_valid = 1'b0; quad_valid = 1'b0;
    count1_done = 1'b0; line_ready = 1'b0;
    x_val = 16'sd0; y_val = 16'sd0;
    quad_v = 2'sd0; quad_w = 2'sd0; quad_x = 2'sd0; quad_y = 2'sd0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst:in_ready", 32'(in_ready), 32'd0);
    check("rst:line_valid", 32'(line_valid), 32'd0);
    check("rst:granule_done", 32'(granule_done), 32'd0);
    check("rst:err", 32'(err), 32'd0);
    check("rst:line_idx_val", {6'd0, line_idx, line_val}, 32'd0);
  endtask

  task automatic run_granule(input string tag, input int bv_in, input int nq, input int ready_pct,
                             input int stall, input int stall_pairs, input bit exp_err,
                             input bit fixed_data);
    int bvc, pi, qi, acc, done_cnt, cyc;
    bit c1_sent, last_flag, finished, hold_pend, r;
    logic [31:0] held;
    bvc = (bv_in > NL / 2) ? NL / 2 : bv_in;
    if (!fixed_data) gen_random(bvc, nq);
    build_model(bvc, nq);
    pi = 0; qi = 0; acc = 0; done_cnt = 0; cyc = 0;
    c1_sent = 1'b0; last_flag = 1'b0; finished = 1'b0; hold_pend = 1'b0; held = 32'd0;
    start = 1'b1;
    big_values = 9'(bv_in);
    line_ready = 1'b0;
    @(negedge clk);
    while (!finished && cyc < 8000) begin
      start = 1'b0; pair_valid = 1'b0; quad_valid = 1'b0; count1_done = 1'b0;
      if (granule_done) done_cnt++;
      if (last_flag) begin
        check({tag, ":done_pulse"}, 32'(granule_done), 32'd1);
        finished = 1'b1;
        line_ready = 1'b0;
      end else begin
        if (hold_pend) check({tag, ":hold"}, {5'd0, line_valid, line_idx, line_val}, held);
        if (stall > 0 && cyc == stall) begin
          check({tag, ":bp_in_ready"}, 32'(in_ready), 32'd0);
          check({tag, ":bp_pairs"}, 32'(pi), 32'(stall_pairs));
        end
        if (cyc == 3) begin
          start = 1'b1;           // must be ignored outside IDLE
          big_values = 9'd7;
        end
        if (pi < bvc) begin
          if (in_ready) begin
            pair_valid = 1'b1; x_val = px[pi]; y_val = py[pi]; pi++;
          end
        end else if (qi < nq) begin
          if (in_ready) begin
            quad_valid = 1'b1;
            quad_v = qv[qi]; quad_w = qw[qi]; quad_x = qx[qi]; quad_y = qy[qi];
            qi++;
          end
        end else if (!c1_sent) begin
          count1_done = 1'b1;
          c1_sent = 1'b1;
        end
        r = (cyc < stall) ? 1'b0 : ($urandom_range(99, 0) < ready_pct);
        if (line_valid && r && acc < NL) begin
          check({tag, ":line"}, {6'd0, line_idx, line_val}, {6'd0, 10'(acc), exp_lines[acc]});
          acc++;
          if (acc == NL) last_flag = 1'b1;
        end
        hold_pend = line_valid && !r;
        held = {5'd0, 1'b1, line_idx, line_val};
        line_ready = r;
      end
      cyc++;
      @(negedge clk);
    end
    start = 1'b0; pair_valid = 1'b0; quad_valid = 1'b0; count1_done = 1'b0;
    check({tag, ":finished"}, 32'(finished), 32'd1);
    check({tag, ":lines_accepted"}, 32'(acc), 32'(NL));
    check({tag, ":done_after"}, 32'(granule_done), 32'd0);
    check({tag, ":valid_after"}, 32'(line_valid), 32'd0);
    check({tag, ":in_ready_after"}, 32'(in_ready), 32'd0);
    check({tag, ":done_count"}, 32'(done_cnt), 32'd1);
    check({tag, ":err"}, 32'(err), 32'(exp_err & CHK));
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    rst = 1'b1;
    idle_inputs();

    vecs[0] = '{bv: 0,   nq: 0,   ready_pct: 100, stall: 0,  stall_pairs: 0, exp_err: 1'b0};
    vecs[1] = '{bv: 287, nq: 1,   ready_pct: 100, stall: 0,  stall_pairs: 0, exp_err: 1'b1};
    vecs[2] = '{bv: 400, nq: 0,   ready_pct: 100, stall: 0,  stall_pairs: 0, exp_err: 1'b1};
    vecs[3] = '{bv: 20,  nq: 10,  ready_pct: 70,  stall: 30, stall_pairs: 3, exp_err: 1'b0};
    vecs[4] = '{bv: 288, nq: 0,   ready_pct: 60,  stall: 0,  stall_pairs: 0, exp_err: 1'b0};
    vecs[5] = '{bv: 1,   nq: 143, ready_pct: 30,  stall: 0,  stall_pairs: 0, exp_err: 1'b0};
    vecs[6] = '{bv: 50,  nq: 119, ready_pct: 80,  stall: 0,  stall_pairs: 0, exp_err: 1'b0};
    vecs[7] = '{bv: 100, nq: 50,  ready_pct: 100, stall: 12, stall_pairs: 3, exp_err: 1'b0};

    // Fixed granule: pairs (3,-5),(0,7) and one quad (1,-1,0,1).
    do_reset();
    px.delete(); py.delete(); qv.delete(); qw.delete(); qx.delete(); qy.delete();
    px.push_back(16'sd3);  py.push_back(-16'sd5);
    px.push_back(16'sd0);  py.push_back(16'sd7);
    qv.push_back(2'sd1); qw.push_back(-2'sd1); qx.push_back(2'sd0); qy.push_back(2'sd1);
    run_granule("fixed", 2, 1, 100, 0, 0, 1'b0, 1'b1);

    for (int i = 0; i < 8; i++) begin
      do_reset();
      run_granule($sformatf("vec%0d", i), vecs[i].bv, vecs[i].nq, vecs[i].ready_pct,
                  vecs[i].stall, vecs[i].stall_pairs, vecs[i].exp_err, 1'b0);
    end

    for (int i = 0; i < 3; i++) begin
      int bv, nq;
      bv = int'($urandom_range(288, 0));
      nq = int'($urandom_range((NL - 2 * bv) / 4, 0));
      do_reset();
      run_granule($sformatf("rand%0d", i), bv, nq, int'($urandom_range(100, 40)),
                  0, 0, 1'b0, 1'b0);
    end

    // Reset in the middle of BIG, then a clean granule without another reset.
    do_reset();
    start = 1'b1;
    big_values = 9'd50;
    @(negedge clk);
    start = 1'b0;
    line_ready = 1'b1;
    sent = 0;
    for (int c = 0; c < 200 && sent < 10; c++) begin
      pair_valid = in_ready;
      if (in_ready) begin
        x_val = 16'($urandom);
        y_val = 16'($urandom);
        sent++;
      end
      @(negedge clk);
    end
    pair_valid = 1'b0;
    check("midrst:pairs_sent", 32'(sent), 32'd10);
    rst = 1'b1;
    @(negedge clk);
    check("midrst:in_ready", 32'(in_ready), 32'd0);
    check("midrst:line_valid", 32'(line_valid), 32'd0);
    check("midrst:line_idx_val", {6'd0, line_idx, line_val}, 32'd0);
    check("midrst:done_err", {30'd0, granule_done, err}, 32'd0);
    rst = 1'b0;
    line_ready = 1'b0;
    run_granule("after_rst", 30, 20, 90, 0, 0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
